// File: rtl/rotary_pkg.sv
// -----------------------------------------------------------------------------
// rotary_pkg
// Shared constants and helpers for the quadrature rotary-encoder front end.
//   DIR_CW / DIR_CCW   : encoding of rot_dir (A leads = CW = 0).
//   FILTER_CYCLES_DEF  : default debounce length in synchronised samples.
//   filt_cnt_w()       : bits needed to count 0..n inclusive.
// -----------------------------------------------------------------------------
package rotary_pkg;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  localparam int FILTER_CYCLES_DEF = 4;

  // Width of a counter that must be able to hold the value n.
  function automatic int filt_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : rotary_pkg

// File: rtl/rot_filter.sv
// -----------------------------------------------------------------------------
// rot_filter
// Two-flop synchroniser followed by a debounce filter for one encoder contact.
// The filtered output only follows the synchronised input after it has
// disagreed on FILTER_CYCLES consecutive clock edges; any agreeing sample
// restarts the count.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   raw    in  raw contact (asynchronous, bouncy)
//   filt   out debounced, synchronised contact level
// -----------------------------------------------------------------------------
module rot_filter
  import rotary_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int             CW   = filt_cnt_w(FILTER_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(FILTER_CYCLES - 1);

  logic          sync_1;
  logic          sync_s;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_s <= 1'b0;
      filt   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_s <= sync_1;
      if (sync_s == filt) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        // This edge is the FILTER_CYCLES-th consecutive disagreement.
        filt <= sync_s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule : rot_filter

// File: rtl/rotary_decoder.sv
// -----------------------------------------------------------------------------
// rotary_decoder
// Quadrature encoder front end: synchronise + debounce A/B, decode each detent
// into a rot_event level, a rot_step pulse and a rot_dir direction bit.
// Optional feature macro: ROT_STEP_COUNT_EN adds a signed detent counter.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rot_a      in   raw contact A
//   rot_b      in   raw contact B
//   rot_event  out  high while the decoded "both closed" state holds
//   rot_dir    out  0 = clockwise (A leads), 1 = counter-clockwise (B leads)
//   rot_step   out  one-cycle pulse on the rot_event rising edge
//   step_count out  signed detent count, CNT_W bits (ROT_STEP_COUNT_EN only)
// -----------------------------------------------------------------------------
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
`ifdef ROT_STEP_COUNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rot_a,
  input  logic             rot_b,
  output logic             rot_event,
  output logic             rot_dir,
  output logic             rot_step
`ifdef ROT_STEP_COUNT_EN
  ,
  output logic [CNT_W-1:0] step_count
`endif
);

  // Arming needs "both open" seen for longer than the filter plus
  // synchroniser can still be showing stale reset zeros; contacts held closed
  // through reset reach the filter outputs before this streak completes.
  localparam int            ARM_LAST = FILTER_CYCLES + 2;
  localparam int            AW       = filt_cnt_w(ARM_LAST);
  localparam logic [AW-1:0] ARM_END  = AW'(ARM_LAST);

  logic          f_a;
  logic          f_b;
  logic          q1;
  logic          q2;
  logic          armed;
  logic [AW-1:0] arm_cnt;

  rot_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (rot_a),
    .filt (f_a)
  );

  rot_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (rot_b),
    .filt (f_b)
  );

  logic both_closed;
  logic both_open;
  logic step_start;

  assign both_closed = f_a & f_b;
  assign both_open   = ~f_a & ~f_b;
  // q1 is about to rise: this edge latches the direction.
  assign step_start  = both_closed & ~q1 & armed;

  // Decode registers. q2 remembers which contact closed alone last; when
  // both change together it simply holds, so direction comes from history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      if (both_closed)    q1 <= 1'b1;
      else if (both_open) q1 <= 1'b0;
      if (~f_a & f_b)     q2 <= 1'b1;
      else if (f_a & ~f_b) q2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (!both_open) begin
        arm_cnt <= '0;
      end else if (arm_cnt == ARM_END) begin
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_dir   <= DIR_CW;
      rot_event <= 1'b0;
      rot_step  <= 1'b0;
    end else begin
      if (step_start) rot_dir <= q2;
      rot_event <= q1 & armed;
      rot_step  <= q1 & armed & ~rot_event;
    end
  end

`ifdef ROT_STEP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count <= '0;
    end else if (rot_step) begin
      // Wraps modulo 2^CNT_W by construction.
      if (rot_dir == DIR_CW) step_count <= step_count + CNT_W'(1);
      else                   step_count <= step_count - CNT_W'(1);
    end
  end
`endif

endmodule : rotary_decoder

// File: tb/tb_rotary_decoder.sv
// -----------------------------------------------------------------------------
// tb_rotary_decoder
// Directed bench for rotary_decoder at FILTER_CYCLES = 4. Inputs change on
// the falling edge; outputs are sampled on the falling edge, half a period
// after the active edge. Define ROT_STEP_COUNT_EN to also cover step_count.
// -----------------------------------------------------------------------------
module tb_rotary_decoder;

  localparam logic CW  = 1'b0;
  localparam logic CCW = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rot_a = 1'b0;
  logic rot_b = 1'b0;
  logic rot_event;
  logic rot_dir;
  logic rot_step;
`ifdef ROT_STEP_COUNT_EN
  logic [7:0] step_count;
`endif

  rotary_decoder #(.FILTER_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rot_a     (rot_a),
    .rot_b     (rot_b),
    .rot_event (rot_event),
    .rot_dir   (rot_dir),
    .rot_step  (rot_step)
`ifdef ROT_STEP_COUNT_EN
    ,
    .step_count(step_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Event monitor, sampled 2 ns after each active edge.
  int   n_step   = 0;
  int   n_rise   = 0;
  int   bad_step = 0;
  int   dir_bad  = 0;
  logic ev_prev  = 1'b0;
  logic dir_prev = 1'b0;
  always @(posedge clk) begin
    #2;
    if (rot_step) n_step++;
    if (rot_event && !ev_prev) n_rise++;
    if (rot_step && (!rot_event || ev_prev)) bad_step++;
    if (rot_event && ev_prev && (rot_dir != dir_prev)) dir_bad++;
    ev_prev  = rot_event;
    dir_prev = rot_dir;
  end

  task automatic do_step(input logic dir);
    if (dir == CW) rot_a = 1'b1; else rot_b = 1'b1;
    tick(10);
    if (dir == CW) rot_b = 1'b1; else rot_a = 1'b1;
    tick(10);
    if (dir == CW) rot_a = 1'b0; else rot_b = 1'b0;
    tick(10);
    if (dir == CW) rot_b = 1'b0; else rot_a = 1'b0;
    tick(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    int fa_bad;

    // 1. Reset with contacts open.
    rst_n = 1'b0;
    tick(3);
    check("rst_event", rot_event, 0);
    check("rst_dir",   rot_dir,   0);
    check("rst_step",  rot_step,  0);
`ifdef ROT_STEP_COUNT_EN
    check("rst_count", step_count, 0);
`endif
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (rot_event || rot_step || rot_dir) quiet++;
    end
    check("open_quiet", quiet, 0);

    // 2. CW step with latency checks.
    n_step = 0;
    rot_a = 1'b1;
    tick(20);
    rot_b = 1'b1;
    tick(7);
    check("cw_ev_7", rot_event, 0);
    check("cw_dir_7", rot_dir, CW);
    tick(1);
    check("cw_ev_8", rot_event, 1);
    check("cw_step_8", rot_step, 1);
    tick(1);
    check("cw_step_9", rot_step, 0);
    check("cw_ev_9", rot_event, 1);
    tick(11);
    rot_a = 1'b0;
    tick(10);
    rot_b = 1'b0;
    tick(7);
    check("cw_fall_7", rot_event, 1);
    tick(1);
    check("cw_fall_8", rot_event, 0);
    tick(10);
    check("cw_nstep", n_step, 1);

    // 3. CCW step: direction valid one edge before event rises.
    n_step = 0;
    rot_b = 1'b1;
    tick(20);
    rot_a = 1'b1;
    tick(6);
    check("ccw_dir_6", rot_dir, CW);
    tick(1);
    check("ccw_dir_7", rot_dir, CCW);
    check("ccw_ev_7", rot_event, 0);
    tick(1);
    check("ccw_ev_8", rot_event, 1);
    check("ccw_step_8", rot_step, 1);
    tick(20);
    rot_b = 1'b0;
    tick(10);
    rot_a = 1'b0;
    tick(20);
    check("ccw_ev_off", rot_event, 0);
    check("ccw_dir_hold", rot_dir, CCW);
    check("ccw_nstep", n_step, 1);

    // 4. Bounce on A with B open, then a short pulse.
    n_step = 0;
    n_rise = 0;
    fa_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) rot_a = ~rot_a;
      tick(1);
      if (dut.f_a) fa_bad++;
    end
    rot_a = 1'b0;
    tick(5);
    rot_a = 1'b1;
    tick(3);
    rot_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (dut.f_a) fa_bad++;
    end
    check("bounce_fa", fa_bad, 0);
    check("bounce_nstep", n_step, 0);
    check("bounce_nrise", n_rise, 0);
    do_step(CW);
    check("bounce_then_step", n_step, 1);
    check("bounce_step_dir", rot_dir, CW);

    // 5a. Reset with contacts closed: no event until re-armed.
    rot_a = 1'b1;
    rot_b = 1'b1;
    do_reset();
    n_step = 0;
    tick(40);
    check("closed_nstep", n_step, 0);
    check("closed_ev", rot_event, 0);
    rot_a = 1'b0;
    rot_b = 1'b0;
    tick(25);
    do_step(CW);
    check("closed_then_step", n_step, 1);

    // 5b. Reset asserted while rot_event is high.
    rot_a = 1'b1;
    tick(10);
    rot_b = 1'b1;
    tick(9);
    check("mid_ev_high", rot_event, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_event", rot_event, 0);
    check("mid_rst_step",  rot_step,  0);
    check("mid_rst_dir",   rot_dir,   0);
    tick(2);
    rst_n = 1'b1;
    n_step = 0;
    tick(30);
    check("mid_no_rearm", n_step, 0);
    rot_a = 1'b0;
    rot_b = 1'b0;
    tick(25);
    do_step(CCW);
    check("mid_rearm_step", n_step, 1);
    check("mid_rearm_dir", rot_dir, CCW);

`ifdef ROT_STEP_COUNT_EN
    // 6. Signed detent counter.
    do_reset();
    tick(20);
    for (int i = 0; i < 3; i++) do_step(CW);
    for (int i = 0; i < 5; i++) do_step(CCW);
    check("cnt_minus2", step_count, 8'hFE);
    do_reset();
    tick(20);
    for (int i = 0; i < 127; i++) do_step(CW);
    check("cnt_127", step_count, 8'h7F);
    do_step(CW);
    check("cnt_wrap", step_count, 8'h80);
`endif

    check("step_coincident", bad_step, 0);
    check("dir_stable", dir_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rotary_decoder
